event_counter: RTL

EVENT_COUNTER -- requirements
Module: event_counter

---
 rtl/event_counter_pkg.sv | 22 ++
 rtl/event_counter_rise_det.sv | 24 ++
 rtl/event_counter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/event_counter_pkg.sv
// Shared encodings for the event counter: mode selectors and the per-cycle
// action chosen by the priority decoder.
package event_counter_pkg;

   // EDGE_MODE encodings
   localparam int MODE_LEVEL = 0;
   localparam int MODE_EDGE  = 1;

   // SAT_MODE encodings
   localparam int MODE_WRAP  = 0;
   localparam int MODE_SAT   = 1;

   // What the counter does on a given cycle, after priority resolution.
   typedef enum logic [2:0] {
      ACT_HOLD = 3'd0,
      ACT_CLR  = 3'd1,
      ACT_LOAD = 3'd2,
      ACT_INC  = 3'd3,
      ACT_DEC  = 3'd4
   } action_e;

endpackage : event_counter_pkg

// File: rtl/event_counter_rise_det.sv
// One-bit rising-edge detector. The history bit is registered; the pulse
// itself is combinational so a rise is usable in the same cycle it is seen.
module rise_det (
   input  logic clk,
   input  logic n_rst,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   // Previous-cycle sample of the input, cleared by reset so a level that is
   // already high at release is treated as a fresh rise.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d_i;
      end
   end

   assign rise_o = d_i & ~d_q;

endmodule : rise_det

// File: rtl/event_counter.sv
// Up/down event counter with clear, load, optional edge qualification of the
// step requests, wrap or saturate at the boundaries, a one-cycle terminal
// count pulse and sticky overflow/underflow flags.
module event_counter
   import event_counter_pkg::*;
#(
   parameter int WIDTH     = 2,
   parameter int EDGE_MODE = 1,
   parameter int SAT_MODE  = 0
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic             dn,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam bit               SATURATE = (SAT_MODE == MODE_SAT);

   logic             inc;
   logic             dec;
   action_e          action;

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   // Step qualification: raw levels in level mode, rising edges otherwise.
   // The edge history runs every cycle regardless of clr/load, so a request
   // held high across a clear or load does not step afterwards.
   generate
      if (EDGE_MODE == MODE_LEVEL) begin : g_level
         assign inc = up;
         assign dec = dn;
      end else begin : g_edge
         rise_det u_rise_up (
            .clk    (clk),
            .n_rst  (n_rst),
            .d_i    (up),
            .rise_o (inc)
         );
         rise_det u_rise_dn (
            .clk    (clk),
            .n_rst  (n_rst),
            .d_i    (dn),
            .rise_o (dec)
         );
      end
   endgenerate

   // Priority decode: clear beats load beats step; simultaneous inc and dec
   // cancel out and leave everything as it was.
   always_comb begin
      action = ACT_HOLD;
      if (clr) begin
         action = ACT_CLR;
      end else if (load) begin
         action = ACT_LOAD;
      end else if (inc && !dec) begin
         action = ACT_INC;
      end else if (dec && !inc) begin
         action = ACT_DEC;
      end
   end

   // Next-state computation. tc defaults low so it only ever lasts one cycle
   // per boundary event; the sticky flags only change on clear or a boundary.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      case (action)
         ACT_CLR: begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
         end
         ACT_LOAD: begin
            count_d = load_val;
         end
         ACT_INC: begin
            if (count_q == ALL_ONES) begin
               tc_d    = 1'b1;
               ovf_d   = 1'b1;
               count_d = SATURATE ? ALL_ONES : '0;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end
         ACT_DEC: begin
            if (count_q == '0) begin
               tc_d    = 1'b1;
               unf_d   = 1'b1;
               count_d = SATURATE ? '0 : ALL_ONES;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
         default: begin
         end
      endcase
   end

   // Counter state registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule : event_counter
